// File: rtl/f_pc_unit.sv
// Fetch-stage PC generator with fetch address-error detection.
// Optional FETCH_RANGE_CHECK_EN adds an IM_BASE/IM_SIZE window check to the fault.
module f_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'hbfc00000,
  parameter logic [31:0] EXC_PC    = 32'hbfc00380,
  parameter logic [31:0] IM_BASE   = 32'hbfc00000,
  parameter logic [31:0] IM_SIZE   = 32'h00010000,
  parameter logic [4:0]  ADEL_CODE = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic [4:0]  F_exc,
  output logic        F_bd,
  output logic [31:0] F_badvaddr,
  output logic [31:0] im_addr
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        fault_s;

  function automatic logic is_cti(input logic [31:0] instr);
    logic r;
    case (instr[31:26])
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: r = 1'b1;
      6'h00:   r = (instr[5:0] == 6'h08) || (instr[5:0] == 6'h09);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

`ifdef FETCH_RANGE_CHECK_EN
  logic [32:0] im_end_s;
  logic        out_of_range_s;

  // Window limit is formed in 33 bits so IM_BASE + IM_SIZE cannot wrap.
  always_comb begin
    im_end_s       = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    out_of_range_s = ({1'b0, pc_q} < {1'b0, IM_BASE}) || ({1'b0, pc_q} >= im_end_s);
  end
  assign fault_s = (pc_q[1:0] != 2'b00) || out_of_range_s;
`else
  assign fault_s = (pc_q[1:0] != 2'b00);
`endif

  // Fetch exception outputs, masked so a faulting fetch carries no instruction.
  always_comb begin
    if (fault_s) begin
      F_exc      = ADEL_CODE;
      F_badvaddr = pc_q;
      F_instr    = 32'h0000_0000;
    end else begin
      F_exc      = 5'd0;
      F_badvaddr = 32'h0000_0000;
      F_instr    = im_rdata;
    end
  end

  // Next-PC arbitration; redirects seen during a stall are parked until en.
  always_comb begin
    pc_d          = pc_q;
    bd_d          = bd_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (req) begin
      pc_d         = EXC_PC;
      bd_d         = 1'b0;
      pend_valid_d = 1'b0;
    end else if (eret) begin
      pc_d         = epc;
      bd_d         = 1'b0;
      pend_valid_d = 1'b0;
    end else if (en) begin
      bd_d         = is_cti(F_instr);
      pend_valid_d = 1'b0;
      if (redirect_valid) begin
        pc_d = redirect_target;
      end else if (pend_valid_q) begin
        pc_d = pend_target_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else begin
      if (redirect_valid) begin
        pend_valid_d  = 1'b1;
        pend_target_d = redirect_target;
      end else begin
        pend_valid_d  = pend_valid_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      bd_q          <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      bd_q          <= bd_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign F_pc    = pc_q;
  assign F_bd    = bd_q;
  assign im_addr = pc_q;

endmodule

// File: tb/tb_f_pc_unit.sv
// Scoreboard bench for f_pc_unit: driver queues hand-computed expectations,
// monitor pops one entry after every clock edge that follows a driven vector.
module tb_f_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BEQ = 32'h1000_0003;

  logic        clk = 1'b0;
  logic        reset, req, eret, en, redirect_valid;
  logic [31:0] epc, redirect_target, im_rdata;
  logic [31:0] F_pc, F_instr, F_badvaddr, im_addr;
  logic [4:0]  F_exc;
  logic        F_bd;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] instr;
    logic [31:0] badv;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   vec_no = 0;

  f_pc_unit dut (
    .clk(clk), .reset(reset), .req(req), .eret(eret), .epc(epc), .en(en),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .im_rdata(im_rdata), .F_pc(F_pc), .F_instr(F_instr), .F_exc(F_exc),
    .F_bd(F_bd), .F_badvaddr(F_badvaddr), .im_addr(im_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, req_v);
    end
  endtask

  // Drive one cycle of inputs at negedge; queue the outputs expected after the next posedge.
  // exc_def applies without the range check, exc_rc with FETCH_RANGE_CHECK_EN.
  task automatic step(input logic rst, input logic rq, input logic er, input logic [31:0] ep,
                      input logic e, input logic rv, input logic [31:0] rt, input logic [31:0] rd,
                      input logic [31:0] xpc, input logic xbd, input logic [4:0] exc_def,
                      input logic [4:0] exc_rc);
    exp_t x;
    @(negedge clk);
    reset = rst; req = rq; eret = er; epc = ep; en = e;
    redirect_valid = rv; redirect_target = rt; im_rdata = rd;
    x.idx = vec_no;
    x.pc  = xpc;
    x.bd  = xbd;
`ifdef FETCH_RANGE_CHECK_EN
    x.exc = exc_rc;
`else
    x.exc = exc_def;
`endif
    x.instr = (x.exc != 5'd0) ? 32'h0 : rd;
    x.badv  = (x.exc != 5'd0) ? xpc : 32'h0;
    exp_q.push_back(x);
    vec_no++;
  endtask

  // Monitor: compare every queued expectation one step after the active edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk(x.idx, "F_pc",       F_pc,            x.pc);
        chk(x.idx, "im_addr",    im_addr,         x.pc);
        chk(x.idx, "F_bd",       {31'd0, F_bd},   {31'd0, x.bd});
        chk(x.idx, "F_exc",      {27'd0, F_exc},  {27'd0, x.exc});
        chk(x.idx, "F_instr",    F_instr,         x.instr);
        chk(x.idx, "F_badvaddr", F_badvaddr,      x.badv);
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1; req = 1'b0; eret = 1'b0; en = 1'b0; redirect_valid = 1'b0;
    epc = 32'h0; redirect_target = 32'h0; im_rdata = NOP;
    //    rst  req  eret epc          en   rv   target       rdata  exp_pc       bd   exc   exc_rc
    step(1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       NOP, 32'hbfc00000,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00004,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00008,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc0000c,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00010,1'b0,5'd0,5'd0);
    // beq fetched at bfc00010 marks the next fetch as a delay slot
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       BEQ, 32'hbfc00014,1'b1,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hbfc00020,NOP, 32'hbfc00020,1'b0,5'd0,5'd0);
    // redirect during stall is held until en
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hbfc00100,NOP, 32'hbfc00020,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       NOP, 32'hbfc00020,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00100,1'b0,5'd0,5'd0);
    // misaligned target faults; masked beq does not set a delay slot
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hbfc00102,NOP, 32'hbfc00102,1'b0,5'd4,5'd4);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       BEQ, 32'hbfc00106,1'b0,5'd4,5'd4);
    step(1'b0,1'b1,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00380,1'b0,5'd0,5'd0);
    // req while stalled with pending redirect discards it
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hbfc00200,NOP, 32'hbfc00380,1'b0,5'd0,5'd0);
    step(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,       NOP, 32'hbfc00380,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b1,32'hbfc00040,1'b0,1'b0,32'h0,       NOP, 32'hbfc00040,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00044,1'b0,5'd0,5'd0);
    // delay-slot flag holds in stall, eret clears it
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       BEQ, 32'hbfc00048,1'b1,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       NOP, 32'hbfc00048,1'b1,5'd0,5'd0);
    step(1'b0,1'b0,1'b1,32'hbfc00060,1'b0,1'b0,32'h0,       NOP, 32'hbfc00060,1'b0,5'd0,5'd0);
    // second stalled redirect overwrites the first
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hbfc00300,NOP, 32'hbfc00060,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hbfc00400,NOP, 32'hbfc00060,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00400,1'b0,5'd0,5'd0);
    // live redirect beats pending one and clears it
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hbfc00500,NOP, 32'hbfc00400,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hbfc00600,NOP, 32'hbfc00600,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00604,1'b0,5'd0,5'd0);
    // req and redirect together: req wins
    step(1'b0,1'b1,1'b0,32'h0,       1'b1,1'b1,32'hbfc00700,NOP, 32'hbfc00380,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00384,1'b0,5'd0,5'd0);
    // reset clears a pending redirect
    step(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'hbfc00800,NOP, 32'hbfc00384,1'b0,5'd0,5'd0);
    step(1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       NOP, 32'hbfc00000,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'hbfc00004,1'b0,5'd0,5'd0);
    // pc+4 wraps at 2^32
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hfffffffc,NOP, 32'hfffffffc,1'b0,5'd0,5'd4);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       NOP, 32'h00000000,1'b0,5'd0,5'd4);
    // window boundaries
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hbfc10000,NOP, 32'hbfc10000,1'b0,5'd0,5'd4);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hbfc0fffc,NOP, 32'hbfc0fffc,1'b0,5'd0,5'd0);
    step(1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1,32'hbfbffffc,NOP, 32'hbfbffffc,1'b0,5'd0,5'd4);
    @(negedge clk);
    en = 1'b0; redirect_valid = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
